// File: rtl/sdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdio_pkg
//  Description : Shared types and constants for the SD SPI transmit block.
//                The CRC state and CRC helper exist only when
//                SDIO_SPI_TX_CRC16_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdio_pkg;

    localparam int          DWIDTH_DEF     = 8;
    localparam int          FIFO_DEPTH_DEF = 4;
    localparam logic [15:0] CRC16_POLY     = 16'h1021;

`ifdef SDIO_SPI_TX_CRC16_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CRC   = 2'd2
    } sdio_state_t;

    // One bit of a serial CRC16-CCITT: feedback is the outgoing bit XOR CRC MSB
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } sdio_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/sdio_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sdio_sync_fifo
//  Description : Single-clock FIFO with show-ahead read data and a registered
//                occupancy count. A push into a full FIFO is accepted only
//                when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdio_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sdio_spi_tx
//  Description : PIC-to-SD-card SPI transmitter. Words written from the PIC
//                are queued in a FIFO and shifted MSB first on DO, one bit per
//                falling edge of the card's SCLK, while card select is low.
//                Optional CRC16 trailer enabled by SDIO_SPI_TX_CRC16_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdio_spi_tx
    import sdio_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              ICLK,
    input  logic              ResetN,
    input  logic [DWIDTH-1:0] csabus,
    input  logic              WriteN,
    input  logic              SCLK,
    input  logic              CD,
`ifdef SDIO_SPI_TX_CRC16_EN
    input  logic              CrcSendN,
`endif
    output logic              DO,
    output logic              RdyN,
    output logic              CmdN,
    output logic [LW-1:0]     Level,
    output logic              Ovf
);

    // Counter must reach DWIDTH-1 for data and 15 for the CRC trailer
    localparam int BCW = $clog2((DWIDTH > 16) ? DWIDTH : 16);

    sdio_state_t       state;
    logic [DWIDTH-1:0] shreg;
    logic [BCW-1:0]    bit_cnt;
    logic              sclk_s1, sclk_s2, sclk_d;
    logic              cd_s1, cd_s2;
    logic              sclk_fall;
    logic              fifo_full, fifo_empty;
    logic [DWIDTH-1:0] fifo_head;
    logic              push, pop;
    logic              word_end;
`ifdef SDIO_SPI_TX_CRC16_EN
    logic [15:0]       crc;
    logic [15:0]       crc_nxt;
    logic              crc_req;
`endif

    sdio_sync_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ICLK),
        .rst_n (ResetN),
        .push  (push),
        .pop   (pop),
        .wdata (csabus),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (Level)
    );

    assign push      = ~WriteN;
    assign RdyN      = fifo_full;
    assign sclk_fall = sclk_d & ~sclk_s2;
    assign word_end  = (state == ST_SHIFT) && !cd_s2 && sclk_fall &&
                       (bit_cnt == BCW'(DWIDTH - 1));
`ifdef SDIO_SPI_TX_CRC16_EN
    assign crc_nxt   = crc16_step(crc, shreg[DWIDTH-1]);
`endif

    // Pop when starting from idle or when a word ends and another is queued
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if ((state == ST_IDLE) && !cd_s2) pop = 1'b1;
            if (word_end)                     pop = 1'b1;
        end
    end

    // Two-flop synchronisers plus one delay flop for SCLK fall detection
    always_ff @(posedge ICLK) begin
        if (!ResetN) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            cd_s1   <= 1'b1;
            cd_s2   <= 1'b1;
        end else begin
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cd_s1   <= CD;
            cd_s2   <= cd_s1;
        end
    end

    // Sticky overflow: a write arrived while full and nothing left the FIFO
    always_ff @(posedge ICLK) begin
        if (!ResetN) begin
            Ovf <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            Ovf <= 1'b1;
        end
    end

    // Transmit state machine with registered DO and CmdN
    always_ff @(posedge ICLK) begin
        if (!ResetN) begin
            state   <= ST_IDLE;
            DO      <= 1'b1;
            CmdN    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef SDIO_SPI_TX_CRC16_EN
            crc     <= '0;
            crc_req <= 1'b0;
`endif
        end else begin
            CmdN <= 1'b1;
`ifdef SDIO_SPI_TX_CRC16_EN
            if (!CrcSendN) crc_req <= 1'b1;
`endif
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg   <= fifo_head;
                        DO      <= fifo_head[DWIDTH-1];
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        DO <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cd_s2) begin
                        // Card deselected: drop the partial word silently
                        state   <= ST_IDLE;
                        DO      <= 1'b1;
                        bit_cnt <= '0;
                    end else if (sclk_fall) begin
`ifdef SDIO_SPI_TX_CRC16_EN
                        crc <= crc_nxt;
`endif
                        if (word_end) begin
                            CmdN    <= 1'b0;
                            bit_cnt <= '0;
                            if (pop) begin
                                shreg <= fifo_head;
                                DO    <= fifo_head[DWIDTH-1];
`ifdef SDIO_SPI_TX_CRC16_EN
                            end else if (crc_req) begin
                                // crc_nxt already includes the last data bit
                                state   <= ST_CRC;
                                DO      <= crc_nxt[15];
                                crc     <= crc_nxt;
                                crc_req <= 1'b0;
`endif
                            end else begin
                                state <= ST_IDLE;
                                DO    <= 1'b1;
                            end
                        end else begin
                            shreg   <= shreg << 1;
                            DO      <= shreg[DWIDTH-2];
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
`ifdef SDIO_SPI_TX_CRC16_EN
                ST_CRC: begin
                    if (cd_s2) begin
                        state   <= ST_IDLE;
                        DO      <= 1'b1;
                        bit_cnt <= '0;
                        crc     <= '0;
                        crc_req <= 1'b0;
                    end else if (sclk_fall) begin
                        if (bit_cnt == BCW'(15)) begin
                            CmdN    <= 1'b0;
                            bit_cnt <= '0;
                            crc     <= '0;
                            state   <= ST_IDLE;
                            DO      <= 1'b1;
                        end else begin
                            crc     <= crc << 1;
                            DO      <= crc[14];
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    DO    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdio_spi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdio_spi_tx
//  Description : Self-checking bench for sdio_spi_tx. Expected DO bits are
//                queued when words are written and compared on each SCLK
//                rising edge, where the card would sample them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdio_spi_tx;

    localparam int DW = 8;
    localparam int LW = 3;

    logic          ICLK   = 1'b0;
    logic          ResetN = 1'b0;
    logic [DW-1:0] csabus = '0;
    logic          WriteN = 1'b1;
    logic          SCLK   = 1'b0;
    logic          CD     = 1'b1;
`ifdef SDIO_SPI_TX_CRC16_EN
    logic          CrcSendN = 1'b1;
`endif
    logic          DO, RdyN, CmdN, Ovf;
    logic [LW-1:0] Level;

    int checks   = 0;
    int failures = 0;
    int cmd_pulses = 0;
    int cmd_wide   = 0;
    logic cmd_prev = 1'b1;
    bit exp_q[$];

    sdio_spi_tx #(.DWIDTH(8), .FIFO_DEPTH(4)) dut (
        .ICLK   (ICLK),
        .ResetN (ResetN),
        .csabus (csabus),
        .WriteN (WriteN),
        .SCLK   (SCLK),
        .CD     (CD),
`ifdef SDIO_SPI_TX_CRC16_EN
        .CrcSendN (CrcSendN),
`endif
        .DO     (DO),
        .RdyN   (RdyN),
        .CmdN   (CmdN),
        .Level  (Level),
        .Ovf    (Ovf)
    );

    always #5 ICLK = ~ICLK;

    // Count CmdN pulses and any pulse lasting more than one cycle
    always @(negedge ICLK) begin
        if (!CmdN && cmd_prev)  cmd_pulses++;
        if (!CmdN && !cmd_prev) cmd_wide++;
        cmd_prev = CmdN;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w, input bit expect_tx);
        @(negedge ICLK);
        csabus = w;
        WriteN = 1'b0;
        if (expect_tx)
            for (int i = DW - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic end_writes();
        @(negedge ICLK);
        WriteN = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge ICLK);
    endtask

    // Card samples DO just before SCLK rises; an empty queue means idle-high
    task automatic bit_cycle();
        bit e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
        check("do_bit", {31'd0, DO}, {31'd0, e});
        SCLK = 1'b1;
        wait_cycles(8);
        SCLK = 1'b0;
        wait_cycles(8);
    endtask

    initial begin
        int base;
        logic [15:0] crc_exp;

        // Reset state
        wait_cycles(4);
        ResetN = 1'b1;
        wait_cycles(2);
        check("rst_do",    {31'd0, DO},   32'd1);
        check("rst_rdyn",  {31'd0, RdyN}, 32'd0);
        check("rst_cmdn",  {31'd0, CmdN}, 32'd1);
        check("rst_level", {29'd0, Level}, 32'd0);
        check("rst_ovf",   {31'd0, Ovf},  32'd0);

        // Single word 0xA5
        CD = 1'b0;
        wait_cycles(4);
        base = cmd_pulses;
        write_word(8'hA5, 1'b1);
        end_writes();
        wait_cycles(2);
        for (int i = 0; i < 8; i++) bit_cycle();
        check("a5_cmd",    cmd_pulses - base, 32'd1);
        check("a5_idle",   {31'd0, DO}, 32'd1);

        // Back-to-back words shift with no gap
        base = cmd_pulses;
        write_word(8'h3C, 1'b1);
        write_word(8'hC3, 1'b1);
        end_writes();
        wait_cycles(2);
        for (int i = 0; i < 16; i++) bit_cycle();
        check("b2b_cmd",   cmd_pulses - base, 32'd2);

        // Deselect mid-word discards it; next word starts from its MSB
        base = cmd_pulses;
        write_word(8'hFF, 1'b1);
        write_word(8'h81, 1'b1);
        end_writes();
        wait_cycles(2);
        for (int i = 0; i < 3; i++) bit_cycle();
        CD = 1'b1;
        wait_cycles(5);
        check("abort_do",    {31'd0, DO}, 32'd1);
        check("abort_cmd",   cmd_pulses - base, 32'd0);
        check("abort_level", {29'd0, Level}, 32'd1);
        for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
        CD = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 8; i++) bit_cycle();
        check("resume_cmd",  cmd_pulses - base, 32'd1);

        // Overflow: four words fill the FIFO, the fifth is dropped
        CD = 1'b1;
        wait_cycles(4);
        base = cmd_pulses;
        write_word(8'h12, 1'b1);
        write_word(8'h9A, 1'b1);
        write_word(8'h56, 1'b1);
        write_word(8'hE7, 1'b1);
        end_writes();
        check("full_rdyn",  {31'd0, RdyN}, 32'd1);
        check("full_level", {29'd0, Level}, 32'd4);
        check("full_ovf0",  {31'd0, Ovf}, 32'd0);
        write_word(8'h00, 1'b0);
        end_writes();
        check("ovf_set",    {31'd0, Ovf}, 32'd1);
        check("ovf_level",  {29'd0, Level}, 32'd4);
        CD = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 40; i++) bit_cycle();
        check("drain_cmd",   cmd_pulses - base, 32'd4);
        check("drain_level", {29'd0, Level}, 32'd0);
        check("drain_rdyn",  {31'd0, RdyN}, 32'd0);
        check("ovf_sticky",  {31'd0, Ovf}, 32'd1);

        // Reset mid-word aborts with no CmdN pulse
        base = cmd_pulses;
        write_word(8'h00, 1'b1);
        end_writes();
        wait_cycles(2);
        for (int i = 0; i < 2; i++) bit_cycle();
        ResetN = 1'b0;
        wait_cycles(1);
        ResetN = 1'b1;
        exp_q.delete();
        wait_cycles(20);
        check("mrst_cmd",   cmd_pulses - base, 32'd0);
        check("mrst_do",    {31'd0, DO}, 32'd1);
        check("mrst_level", {29'd0, Level}, 32'd0);
        check("mrst_ovf",   {31'd0, Ovf}, 32'd0);

`ifdef SDIO_SPI_TX_CRC16_EN
        // Two 0xFF words then a CRC trailer of CRC16-CCITT(0xFFFF)
        base = cmd_pulses;
        crc_exp = 16'h1D0F;
        write_word(8'hFF, 1'b1);
        write_word(8'hFF, 1'b1);
        end_writes();
        for (int i = 15; i >= 0; i--) exp_q.push_back(crc_exp[i]);
        @(negedge ICLK);
        CrcSendN = 1'b0;
        @(negedge ICLK);
        CrcSendN = 1'b1;
        for (int i = 0; i < 36; i++) bit_cycle();
        check("crc_cmd", cmd_pulses - base, 32'd3);
`else
        crc_exp = 16'h0000;
`endif

        check("queue_empty", exp_q.size(), 32'd0);
        check("cmd_width",   cmd_wide, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sdio_spi_tx.md
SDIO_SPI_TX -- requirements
Module: sdio_spi_tx

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port ICLK, input, 1 bit: the single clock; all logic is rising-edge ICLK.
REQ-004 SHALL have port ResetN, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port csabus, input, DWIDTH bits: write data from the PIC.
REQ-006 SHALL have port WriteN, input, 1 bit: active-low write strobe; each ICLK cycle it is low is one write.
REQ-007 SHALL have port SCLK, input, 1 bit: SD SPI clock, asynchronous to ICLK.
REQ-008 SHALL have port CD, input, 1 bit: card select, active-low, asynchronous.
REQ-009 SHALL have port DO, output, 1 bit: serial data to the card, MSB first.
REQ-010 SHALL have port RdyN, output, 1 bit: low when the FIFO is not full.
REQ-011 SHALL have port CmdN, output, 1 bit: one-cycle low pulse when a word has been completely shifted.
REQ-012 SHALL have port Level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-013 SHALL have port Ovf, output, 1 bit: sticky flag set when a write is dropped.

Function
REQ-014 SHALL pass SCLK and CD through 2-flop synchronisers, then detect SCLK falling edges with one extra flop (detected 3 cycles after the pin edge); ICLK must run at least 4x SCLK.
REQ-015 SHALL accept a write when WriteN is low and the FIFO is not full, or when it is full and a pop happens in the same cycle; Level SHALL update one cycle after the write.
REQ-016 SHALL drop a write made while the FIFO is full with no pop, and SHALL set Ovf, which stays set until reset.
REQ-017 SHALL implement states IDLE, SHIFT and (with CRC16_EN) CRC.
REQ-018 IDLE -> SHIFT: when synchronised CD is low and FIFO is non-empty, pop the head into the shift register and drive its MSB on DO in the same cycle.
REQ-019 In SHIFT, each detected SCLK fall SHALL advance one bit; the DWIDTH-th fall SHALL end the word and pulse CmdN low for exactly 1 cycle.
REQ-020 At word end, if the FIFO is non-empty and CD is low, the block SHALL pop and load the next word in that same cycle (no idle bit); otherwise it SHALL go to IDLE.
REQ-021 In IDLE, DO SHALL be 1.
REQ-022 If synchronised CD goes high mid-word, the block SHALL discard the partial word, clear the bit counter, go to IDLE, drive DO=1, and not pulse CmdN; FIFO contents are retained.
REQ-023 A write while the FIFO is empty and the state is IDLE with CD low SHALL give first-bit DO valid 2 cycles after the WriteN-low cycle.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; Level SHALL never exceed FIFO_DEPTH.

Reset
REQ-025 While ResetN is low at an ICLK edge, the block SHALL set state=IDLE, FIFO empty, DO=1, RdyN=0, CmdN=1, Level=0, Ovf=0, bit counter=0, CRC=0, and clear the synchronisers to SCLK=0 and CD=1.
REQ-026 Reset mid-word SHALL abort the word with no CmdN pulse.

Configuration
REQ-027 Macro SDIO_SPI_TX_CRC16_EN:
- Defined: add input CrcSendN (active-low, 1 cycle). A CRC16-CCITT (poly 0x1021, init 0) SHALL accumulate over every bit shifted in SHIFT.
- On CrcSendN low, a request SHALL be latched; at the next word end with the FIFO empty, the block SHALL enter CRC and shift 16 CRC bits MSB first on SCLK falls, pulse CmdN at the end, clear the CRC, then return to IDLE.
- CD high during CRC SHALL abort as in REQ-022 and clear both the CRC and the request.
REQ-028 Macro undefined: no CrcSendN port, no CRC state and no CRC logic.

Structure
REQ-029 Package sdio_pkg SHALL hold the state enum typedef, the CRC16 polynomial constant and the default DWIDTH and FIFO_DEPTH.
REQ-030 The FIFO SHALL be a separate sub-module, sdio_sync_fifo (parametrised width and depth, push/pop/full/empty/level).

Verification
REQ-031 Reset, then observe with no stimulus -> DO=1, RdyN=0, CmdN=1, Level=0, Ovf=0.
REQ-032 CD=0; write 0xA5; run 8 SCLK cycles -> DO carries 1,0,1,0,0,1,0,1 and there is one CmdN pulse after the 8th fall.
REQ-033 Write 5 words with DEPTH=4 and CD=1 -> RdyN=1 after the 4th write, Level=4, Ovf=1, and the 5th word never appears.
REQ-034 CD=0; write 0x3C and 0xC3 back-to-back -> 16 contiguous bits with no idle gap and two CmdN pulses.
REQ-035 Raise CD after 3 bits of 0xFF -> DO=1, no CmdN pulse; lower CD -> the next FIFO word shifts from its MSB.
REQ-036 With CRC16_EN: send 0xFF×2 then CrcSendN -> the 16 trailing bits equal CRC16-CCITT(0xFFFF) = 0x1D0F, followed by a CmdN pulse.
